// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: in-order {pc, inst} FIFO between fetch and decode
// with single-cycle flush on mispredict.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mispredict,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  head_q, head_d, tail_q, tail_d;
    logic [15:0]  pc_q   [DEPTH];
    logic [31:0]  inst_q [DEPTH];
    logic         empty, full, push, pop;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty     = head_q == tail_q;
    assign full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign in_ready  = !full;
    assign out_valid = !empty && !mispredict;
    assign push      = in_valid && in_ready && !mispredict;
    assign pop       = out_valid && out_ready;
    assign out_pc    = out_valid ? pc_q[head_q[AW-1:0]] : '0;
    assign out_inst  = out_valid ? inst_q[head_q[AW-1:0]] : '0;
    assign count     = CW'(tail_q - head_q);

    always_comb begin
        head_d = mispredict ? '0 : head_q + (AW+1)'(pop);
        tail_d = mispredict ? '0 : tail_q + (AW+1)'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is never cleared; only the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_q[tail_q[AW-1:0]]   <= in_pc;
            inst_q[tail_q[AW-1:0]] <= in_inst;
        end
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Decoupling FIFO between the fetch stage and the decode stage of the out-of-order core. It absorbs fetch bandwidth while decode is stalled by rename/ROB/LSU back-pressure, so IM reads keep flowing. It holds {pc, inst} pairs in program order and discards all contents in one cycle on a branch mispredict.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mispredict  input  1  flush request from the execute stage
- in_valid  input  1  fetch stage presents an instruction
- in_ready  output  1  queue accepts a push this cycle
- in_pc  input  16  PC of the pushed instruction
- in_inst  input  32  pushed instruction word
- out_valid  output  1  head entry presented to decode
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  16  PC of the head entry
- out_inst  output  32  instruction word of the head entry
- count  output  CW  current occupancy, 0..DEPTH

## Operation

- Storage: DEPTH-entry array of {pc[15:0], inst[31:0]}, plus head and tail pointers of width $clog2(DEPTH)+1.
  - The extra MSB is a wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
- Push: when in_valid && in_ready && !mispredict:
  - write the entry at tail[idx];
  - tail increments modulo 2*DEPTH.
- Pop: when out_valid && out_ready, head increments modulo 2*DEPTH.
- Simultaneous push and pop are allowed in any non-empty, non-full state; count is unchanged.
- in_ready = !full. It is combinational from registered state only and never depends on out_ready.
  - A full queue does not accept a push in the same cycle as a pop; the freed slot is visible the next cycle.
- out_valid = !empty && !mispredict.
- out_pc and out_inst:
  - equal the head entry when out_valid = 1;
  - are forced to 0 when out_valid = 0, so no wrong-path value is visible.
- count = tail − head (CW-bit modular subtract). It equals DEPTH when full.
- Flush (mispredict = 1):
  - highest priority; the push and pop in that cycle are both ignored;
  - next cycle head = tail = 0 and count = 0;
  - array contents are not cleared.
- Reset (rst = 1):
  - same pointer effect as a flush; it overrides mispredict and handshakes;
  - valid in any state, including mid-stream.
- No combinational bypass: an entry pushed into an empty queue appears on out_* one cycle later.

## Timing

- Reset values, in the cycle after rst: in_ready=1, out_valid=0, out_pc=0, out_inst=0, count=0.
- Latency from push to out_valid: 1 cycle. Throughput: 1 push and 1 pop per cycle.
- In the mispredict cycle itself: out_valid=0 and in_ready follows !full.
- In the cycle after a flush: queue empty, in_ready=1. A push in that cycle is accepted, and out_valid rises one cycle later.
- The fetch side must hold in_pc/in_inst stable while in_valid && !in_ready. The queue never drops an accepted entry except on flush or reset.
- Pointer wrap: after 2*DEPTH pushes and pops the pointers return to 0 with no change in behaviour.

## Test plan

- Reset, then 3 pushes on consecutive cycles with out_ready=0: pc 0x0000, 0x0004, 0x0008 (inst 0x00000013 each).
  - Required: count 1,2,3; out_valid rises 1 cycle after the first push; out_pc=0x0000 held.
- Fill to DEPTH=4 with out_ready=0, then drive in_valid with pc 0x0010.
  - Required: in_ready=0 and count=4; the pc 0x0010 entry is held, not lost.
  - Then raise out_ready for 1 cycle: head pops; in_ready returns to 1 the next cycle; 0x0010 is accepted and exits in order.
- Steady streaming: push and pop every cycle for 20 cycles, pc 0x0000 upward by 4.
  - Required: count constant at 1; out_pc sequence strictly increasing by 4; pointer wrap passes without error.
- With 3 entries held, assert mispredict for 1 cycle while in_valid=1 and out_ready=1.
  - Required: out_valid=0 that cycle; no pop and no push take effect; next cycle count=0, out_pc=0.
  - Then push pc 0x0040: out_pc=0x0040 one cycle later.
- Assert rst while full and mispredict=1.
  - Required: next cycle count=0, in_ready=1, out_valid=0, out_inst=0.
- Random in_valid/out_ready/mispredict for 10k cycles against a queue model.
  - Required: order preserved, no duplicates, no loss except on flush, 0 ≤ count ≤ 4 at all times.
